term_writer: RTL and testbench
==============================

TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 25, text rows per screen.
REQ-003 Parameter FIFO_DEPTH, default 16, input byte buffer entries (power of two).
REQ-004 clk100  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_data  input  8  received byte from the UART receiver.
REQ-007 in_valid  input  1  single-cycle strobe; in_data valid; no backpressure to the source.
REQ-008 wr_en  output  1  text-RAM write strobe to the VGA text-mode stage.
REQ-009 wr_addr  output  11  cell address, row*COLS+col.
REQ-010 wr_data  output  8  character code to write.
REQ-011 busy  output  1  high whenever state is not IDLE or FIFO is non-empty.
REQ-012 overflow  output  1  one-cycle pulse when an incoming byte is dropped.
REQ-013 cursor_row  output  5  current row, 0..ROWS-1.
REQ-014 cursor_col  output  7  current column, 0..COLS-1.

Function
REQ-015 Every in_valid byte SHALL be pushed into the FIFO unless the FIFO is full at that edge; a full FIFO SHALL drop the byte and pulse overflow, even if a pop occurs the same cycle.
REQ-016 The FSM SHALL have states IDLE, DECODE, CLEAR_ROW, CLEAR_ALL.
REQ-017 IDLE with FIFO non-empty: pop one byte into a holding register, go to DECODE; one byte processed per DECODE visit.
REQ-018 All outputs registered; a printable byte strobed at cycle N into an idle, empty block SHALL produce wr_en high at cycle N+3 for exactly one cycle.
REQ-019 Printable 0x20-0x7E: write byte at (row, col); col+1; if col was COLS-1, col<=0 and perform newline.
REQ-020 0x0D (CR): col<=0, no write, return IDLE.
REQ-021 0x0A (LF): perform newline, col unchanged.
REQ-022 0x08 (BS): col<=col-1 if col>0, else unchanged; no write.
REQ-023 0x09 (TAB): col<=min((col & ~7)+8, COLS-1); no write.
REQ-024 0x0C (FF): enter CLEAR_ALL; afterwards cursor at (0,0).
REQ-025 Other bytes (0x00-0x1F not listed, 0x7F-0xFF): ignored, no write, return IDLE.
REQ-026 Newline: row<=row+1, wrapping ROWS-1 to 0; then CLEAR_ROW on the new row.
REQ-027 CLEAR_ROW: write 0x20 to the COLS cells of the new row, one per cycle, ascending col 0..COLS-1 (COLS consecutive wr_en cycles), then IDLE.
REQ-028 CLEAR_ALL: write 0x20 to addresses 0..ROWS*COLS-1, one per cycle, ascending, then IDLE.
REQ-029 The FIFO SHALL keep accepting bytes during CLEAR_ROW/CLEAR_ALL; bytes are processed in arrival order afterwards.
REQ-030 wr_addr arithmetic SHALL be 11-bit and never exceed ROWS*COLS-1.
REQ-031 cursor_row/cursor_col SHALL reflect the updated cursor on the cycle wr_en for the character is high.

Reset
REQ-032 rst_n low: wr_en=0, wr_addr=0, wr_data=0, overflow=0, cursor (0,0), FIFO empty, state IDLE.
REQ-033 Reset during CLEAR_ROW/CLEAR_ALL SHALL abandon the clear immediately, with no further wr_en.
REQ-034 No automatic screen clear after reset.

Structure
REQ-035 Package term_pkg SHALL hold COLS/ROWS defaults, CELLS=2000, control codes (CR, LF, BS, TAB, FF, SPACE), and the FSM state enum.
REQ-036 The FIFO SHALL be a separate sub-module byte_fifo (DEPTH, push, pop, full, empty, dout).

Verification
REQ-037 Reset, send "A" (0x41) -> one wr_en, wr_addr=0, wr_data=0x41, 3 cycles after strobe; cursor (0,1).
REQ-038 Cursor (3,79), send 0x42 -> write addr 319; cursor (4,0); 80 writes 0x20 at addr 320..399.
REQ-039 Row 24, send LF -> cursor_row=0; 80 writes 0x20 at addr 0..79.
REQ-040 Send FF -> 2000 consecutive writes of 0x20 at addr 0..1999; cursor (0,0); busy low after.
REQ-041 Cursor (0,5): TAB -> col 8; BS x9 -> col 0; CR at col 0 -> col 0; no wr_en.
REQ-042 During CLEAR_ALL strobe 17 bytes -> first 16 written in order afterwards, 17th dropped with one overflow pulse.

Source files
------------

// File: rtl/term_pkg.sv
// ---------------------------------------------------------------------------
// term_pkg
// Shared definitions for the UART-to-VGA text writer: default screen
// geometry, the control codes the writer interprets, the writer FSM state
// type and a small character-class helper.
// ---------------------------------------------------------------------------
package term_pkg;

  localparam int COLS_DEFAULT       = 80;
  localparam int ROWS_DEFAULT       = 25;
  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int CELLS              = 2000;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    CLEAR_ROW = 2'd2,
    CLEAR_ALL = 2'd3
  } state_t;

  // Printable ASCII range that is written to the screen verbatim.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Small synchronous byte FIFO with show-ahead output (dout is the head entry
// whenever empty is low).
//
// Ports
//   clk100  : clock, rising edge
//   rst_n   : synchronous active-low reset (pointers only)
//   push    : write din; ignored while full
//   pop     : discard head entry; ignored while empty
//   din     : byte to write
//   dout    : head entry
//   full    : no free entry
//   empty   : no stored entry
// ---------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk100) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/term_writer.sv
// ---------------------------------------------------------------------------
// term_writer
// Turns a stream of received UART bytes into text-RAM writes for a VGA
// text-mode display. Printable characters are written at the cursor, a small
// set of control codes moves the cursor, newline clears the row it lands on
// and form feed clears the whole screen. Incoming bytes are buffered in a
// FIFO so that reception continues during the multi-cycle clears.
//
// Ports
//   clk100     : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_data    : received byte
//   in_valid   : one-cycle strobe qualifying in_data
//   wr_en      : text-RAM write strobe
//   wr_addr    : cell address, row*COLS+col
//   wr_data    : character code to write
//   busy       : work pending (FSM active or FIFO non-empty)
//   overflow   : one-cycle pulse when a byte was dropped on a full FIFO
//   cursor_row : current cursor row
//   cursor_col : current cursor column
// ---------------------------------------------------------------------------
module term_writer
  import term_pkg::*;
#(
  parameter int COLS       = COLS_DEFAULT,
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        overflow,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);

  localparam logic [10:0] LAST_CELL = 11'(ROWS * COLS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  function automatic logic [10:0] cell_addr(input logic [4:0] row,
                                            input logic [6:0] col);
    return 11'(row) * 11'(COLS) + 11'(col);
  endfunction

  function automatic logic [4:0] next_row(input logic [4:0] row);
    return (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  endfunction

  // Next multiple of 8, clamped to the last column.
  function automatic logic [6:0] tab_stop(input logic [6:0] col);
    logic [7:0] t;
    t = {1'b0, col & 7'h78} + 8'd8;
    return (t > {1'b0, LAST_COL}) ? LAST_COL : t[6:0];
  endfunction

  state_t      state;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic [7:0]  byte_p1;
  logic [10:0] clr_addr;
  logic [10:0] clr_end;
  logic [4:0]  nl_row;
  logic [10:0] nl_base;

  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign nl_row   = next_row(cursor_row);
  assign nl_base  = cell_addr(nl_row, 7'd0);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .push   (in_valid),
    .pop    (fifo_pop),
    .din    (in_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Stage p1: holding register for the byte under decode.
  always_ff @(posedge clk100) begin
    if (fifo_pop) begin
      byte_p1 <= fifo_dout;
    end
  end

  // Stage p2: decode, cursor update and registered write port.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      overflow   <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
      clr_addr   <= '0;
      clr_end    <= '0;
    end else begin
      wr_en    <= 1'b0;
      // full is sampled before any same-cycle pop, so a pop cannot rescue it.
      overflow <= in_valid && fifo_full;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= DECODE;
          end
        end

        DECODE: begin
          state <= IDLE;
          if (is_printable(byte_p1)) begin
            wr_en   <= 1'b1;
            wr_addr <= cell_addr(cursor_row, cursor_col);
            wr_data <= byte_p1;
            if (cursor_col == LAST_COL) begin
              cursor_col <= '0;
              cursor_row <= nl_row;
              clr_addr   <= nl_base;
              clr_end    <= nl_base + 11'(COLS - 1);
              state      <= CLEAR_ROW;
            end else begin
              cursor_col <= cursor_col + 7'd1;
            end
          end else begin
            case (byte_p1)
              CR: cursor_col <= '0;
              LF: begin
                cursor_row <= nl_row;
                clr_addr   <= nl_base;
                clr_end    <= nl_base + 11'(COLS - 1);
                state      <= CLEAR_ROW;
              end
              BS: begin
                if (cursor_col != 7'd0) begin
                  cursor_col <= cursor_col - 7'd1;
                end
              end
              TAB: cursor_col <= tab_stop(cursor_col);
              FF: begin
                cursor_row <= '0;
                cursor_col <= '0;
                clr_addr   <= '0;
                clr_end    <= LAST_CELL;
                state      <= CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end

        CLEAR_ROW, CLEAR_ALL: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_addr;
          wr_data <= SPACE;
          if (clr_addr == clr_end) begin
            state <= IDLE;
          end else begin
            clr_addr <= clr_addr + 11'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_term_writer.sv
module tb_term_writer;
  import term_pkg::*;

  logic        clk100;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        overflow;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  term_writer dut (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .overflow   (overflow),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
    logic        chk;
    logic [4:0]  row;
    logic [6:0]  col;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   ovf_seen   = 0;
  int   m_row      = 0;
  int   m_col      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model of the writer ----------------
  task automatic push_exp(input int a, input int d, input bit chk, input int r, input int c);
    exp_t e;
    e.addr = 11'(a);
    e.data = 8'(d);
    e.chk  = chk;
    e.row  = 5'(r);
    e.col  = 7'(c);
    exp_q.push_back(e);
  endtask

  task automatic clear_row_exp();
    for (int c = 0; c < 80; c++) push_exp(m_row * 80 + c, 8'h20, 1'b0, 0, 0);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int a;
    if (b >= 8'h20 && b <= 8'h7E) begin
      a = m_row * 80 + m_col;
      if (m_col == 79) begin
        m_col = 0;
        m_row = (m_row + 1) % 25;
        push_exp(a, b, 1'b1, m_row, m_col);
        clear_row_exp();
      end else begin
        m_col++;
        push_exp(a, b, 1'b1, m_row, m_col);
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % 25;
      clear_row_exp();
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h09) begin
      m_col = ((m_col / 8) * 8 + 8 > 79) ? 79 : (m_col / 8) * 8 + 8;
    end else if (b == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      for (int i = 0; i < 2000; i++) push_exp(i, 8'h20, 1'b0, 0, 0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk100) begin
    exp_t e;
    if (overflow === 1'b1) ovf_seen++;
    if (wr_en === 1'b1) begin
      check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        if (e.chk) begin
          check("wr_cursor_row", 32'(cursor_row), 32'(e.row));
          check("wr_cursor_col", 32'(cursor_col), 32'(e.col));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk100);
    #1;
    in_data  = b;
    in_valid = 1'b1;
    model_byte(b);
    @(posedge clk100);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk100);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk100);
      n++;
    end
    check(tag, 32'(n < 5000), 32'd1);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, 32'(cursor_row), 32'(m_row));
    check({tag, "_col"}, 32'(cursor_col), 32'(m_col));
  endtask

  initial begin
    int cnt;
    logic [7:0] burst [17];

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_cursor("rst_cursor");
    @(posedge clk100);
    #1;
    rst_n = 1'b1;

    // Single printable: exactly three cycles from strobe to write.
    send_byte(8'h41);
    @(negedge clk100);
    check("lat_n1", 32'(wr_en), 32'd0);
    @(negedge clk100);
    check("lat_n2", 32'(wr_en), 32'd0);
    @(negedge clk100);
    check("lat_n3", 32'(wr_en), 32'd1);
    @(negedge clk100);
    check("lat_n4", 32'(wr_en), 32'd0);
    wait_idle("idle_A");
    check_cursor("cur_A");

    // Move to (3,79): CR, 3 LF, then 10 TABs (last one clamps 72 -> 79).
    send_byte(8'h0D);
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    wait_idle("idle_lf3");
    for (int i = 0; i < 10; i++) send_byte(8'h09);
    wait_idle("idle_tabs");
    check_cursor("cur_3_79");

    // Write at last column wraps and clears row 4.
    send_byte(8'h42);
    wait_idle("idle_wrap");
    check_cursor("cur_4_0");

    // Down to row 24, then LF wraps to row 0.
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h0A);
      wait_idle("idle_lf");
    end
    check_cursor("cur_24");
    send_byte(8'h0A);
    wait_idle("idle_lf_wrap");
    check_cursor("cur_row_wrap");

    // Full clear.
    send_byte(8'h0C);
    wait_idle("idle_ff");
    check_cursor("cur_ff");
    check("busy_after_ff", 32'(busy), 32'd0);

    // Cursor-only codes: none of them may write.
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
    wait_idle("idle_abcde");
    check_cursor("cur_0_5");
    send_byte(8'h09);
    wait_idle("idle_tab");
    check_cursor("cur_tab8");
    for (int i = 0; i < 9; i++) send_byte(8'h08);
    wait_idle("idle_bs");
    check_cursor("cur_bs0");
    send_byte(8'h0D);
    wait_idle("idle_cr");
    check_cursor("cur_cr0");

    // Ignored codes.
    send_byte(8'h00);
    send_byte(8'h1B);
    send_byte(8'h7F);
    send_byte(8'hFF);
    wait_idle("idle_ignored");
    check_cursor("cur_ignored");
    check("ovf_none_yet", 32'(ovf_seen), 32'd0);

    // 17 bytes arriving during a full clear: 16 kept, the last dropped.
    send_byte(8'h0C);
    repeat (4) @(posedge clk100);
    for (int i = 0; i < 17; i++) burst[i] = 8'h48 + 8'(i);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk100);
      #1;
      in_data  = burst[i];
      in_valid = 1'b1;
      if (i < 16) model_byte(burst[i]);
    end
    @(posedge clk100);
    #1;
    in_valid = 1'b0;
    @(negedge clk100);
    check("ovf_pulse", 32'(overflow), 32'd1);
    @(negedge clk100);
    check("ovf_single", 32'(overflow), 32'd0);
    wait_idle("idle_burst");
    check("ovf_count", 32'(ovf_seen), 32'd1);
    check_cursor("cur_burst");

    // Reset in the middle of a full clear abandons it.
    send_byte(8'h0C);
    repeat (20) @(negedge clk100);
    @(posedge clk100);
    #1;
    rst_n = 1'b0;
    @(posedge clk100);
    #1;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk100);
      if (wr_en !== 1'b0) cnt++;
    end
    check("rst_abort_wr", 32'(cnt), 32'd0);
    check("rst_abort_busy", 32'(busy), 32'd0);
    check_cursor("rst_abort_cur");
    @(posedge clk100);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      if (wr_en !== 1'b0) cnt++;
    end
    check("no_auto_clear", 32'(cnt), 32'd0);

    repeat (5) @(negedge clk100);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
